// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle controller:
// FSM state enum, base opcodes, and PC/writeback mux selects.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_HALT    = 3'd5
    } ctrl_state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_IMM  = 2'd3;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        unique case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: is_legal_opcode = 1'b1;
            default:                            is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Counts consecutive request-outstanding cycles without ack; flags expiry on
// the WAIT_MAX-th such cycle so an ack in that same cycle still wins.
module ctrl_wait_timer #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = active && !ack && (count_q == LAST);

    // Any cycle without an outstanding, unacknowledged request restarts the count.
    always_comb begin
        count_d = '0;
        if (active && !ack && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WB/HALT).
// Define MULTICYCLE_CTRL_INSTRET_EN to build the retired-instruction counter.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        branch_taken,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  dmem_size,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] instret
);

    ctrl_state_e state_q, state_d;
    logic        halted_q, halted_d;
    logic        bus_err_q, bus_err_d;
    logic [2:0]  dmem_size_q, dmem_size_d;

    logic wait_active;
    logic wait_ack;
    logic wait_expired;

    // Timer inputs come straight from the state register to keep the enable logic loop-free.
    assign wait_active = rst_n && ((state_q == ST_FETCH) || (state_q == ST_MEM));
    assign wait_ack    = (state_q == ST_FETCH) ? imem_ack : dmem_ack;

    ctrl_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (wait_active),
        .ack     (wait_ack),
        .expired (wait_expired)
    );

    always_comb begin
        state_d     = state_q;
        halted_d    = halted_q;
        bus_err_d   = bus_err_q;
        dmem_size_d = dmem_size_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SRC_PLUS4;
        rf_we       = 1'b0;
        wb_sel      = WB_SEL_ALU;
        alu_src_a   = 1'b0;
        alu_src_b   = 1'b0;

        if (rst_n) begin
            unique case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = ST_DECODE;
                    end else if (wait_expired) begin
                        state_d   = ST_HALT;
                        halted_d  = 1'b1;
                        bus_err_d = 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (is_legal_opcode(opcode)) begin
                        state_d = ST_EXECUTE;
                    end else begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    alu_src_a = (opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_BRANCH);
                    alu_src_b = !((opcode == OP_OP) || (opcode == OP_BRANCH));
                    if (opcode == OP_BRANCH) begin
                        pc_we   = 1'b1;
                        pc_src  = branch_taken ? PC_SRC_TARGET : PC_SRC_PLUS4;
                        state_d = ST_FETCH;
                    end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                        dmem_size_d = funct3;
                        state_d     = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OP_STORE);
                    if (dmem_ack) begin
                        if (opcode == OP_STORE) begin
                            pc_we   = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else if (wait_expired) begin
                        state_d   = ST_HALT;
                        halted_d  = 1'b1;
                        bus_err_d = 1'b1;
                    end
                end
                ST_WB: begin
                    rf_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = ST_FETCH;
                    unique case (opcode)
                        OP_LOAD:         wb_sel = WB_SEL_LOAD;
                        OP_JAL, OP_JALR: wb_sel = WB_SEL_PC4;
                        OP_LUI:          wb_sel = WB_SEL_IMM;
                        default:         wb_sel = WB_SEL_ALU;
                    endcase
                    if (opcode == OP_JAL) begin
                        pc_src = PC_SRC_TARGET;
                    end else if (opcode == OP_JALR) begin
                        pc_src = PC_SRC_JALR;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            halted_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            dmem_size_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            bus_err_q   <= bus_err_d;
            dmem_size_q <= dmem_size_d;
        end
    end

    assign halted    = halted_q;
    assign bus_err   = bus_err_q;
    assign dmem_size = dmem_size_q;

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    // pc_we is never raised in HALT, so the count freezes there without extra gating.
    always_comb begin
        instret_d = instret_q;
        if (pc_we) begin
            instret_d = instret_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule
